regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation superscalar/pipelined RV32/RV64 core.
- Generalises the single-issue 2R1W file:
  - configurable width, depth and read/write port count;
  - optional write-to-read bypass;
  - per-register busy scoreboard, so decode can detect RAW hazards against in-flight producers.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

Parameters:
- XLEN, 32, register width in bits (32 or 64).
- NREGS, 32, number of architectural registers (power of two, 16 or 32); register 0 is hardwired zero.
- NUM_RD, 2, number of combinational read ports (1..6).
- NUM_WR, 1, number of write ports (1..3).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return pre-write contents.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW].
- rs_data  out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rs_busy  out  NUM_RD  register at read port i has an outstanding producer.
- wr_en  in  NUM_WR  write enable per port.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- iss_valid  in  1  an instruction with a destination register is issuing this cycle.
- iss_rd  in  AW  destination of the issuing instruction.
- busy_vec  out  NREGS  raw scoreboard state, for debug/flush logic.
- flush  in  1  clears the entire scoreboard (pipeline flush); register contents are unaffected.

Behaviour:
- Reset: on rst_n low, asynchronously and immediately:
  - all registers = 0; busy_vec = 0.
  - Outputs follow combinationally: rs_data = 0, rs_busy = 0.
  - Reset mid-operation discards any same-cycle writes and issues.
- Register 0:
  - never written (writes to address 0 ignored);
  - reads of address 0 return 0 and rs_busy = 0 regardless of bypass;
  - never marked busy.
- Write:
  - Each rising edge, for each port j with wr_en[j] and wr_addr[j] != 0, regs[wr_addr[j]] <= wr_data[j].
  - Same-address collision between ports: the highest-index port wins, deterministically.
- Read: combinational, zero latency.
  - BYPASS=0: rs_data = stored value.
  - BYPASS=1: if any enabled write port matches rs_addr[i] (nonzero), return that port's wr_data (highest index wins); otherwise the stored value.
- Scoreboard, per register r != 0, next state in priority order:
  - flush -> 0.
  - iss_valid && iss_rd == r -> 1 (a new producer wins over a same-cycle writeback).
  - any wr_en[j] && wr_addr[j] == r -> 0.
  - otherwise hold.
- rs_busy[i]:
  - = busy_vec[rs_addr[i]], but forced 0 when BYPASS=1 and a same-cycle write matches rs_addr[i] (data is available now).
  - Issue in the current cycle does not affect rs_busy until the next cycle (registered).
- Writes always update data even if the register is not busy; writes never set busy.
- Widths: no arithmetic; address compares use the full AW bits; out-of-range addresses cannot occur (NREGS = 2^AW).

Decomposition:
- Shared package core_pkg:
  - XLEN default;
  - NREGS default;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef xlen_t (logic [XLEN-1:0]);
  - localparam REG_ZERO = '0.
- One natural sub-module, regfile_scoreboard:
  - holds busy_vec, the set/clear/flush priority and the rs_busy lookup;
  - the data array, write-collision resolution and bypass mux stay in regfile_mp.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with pending writes (x5 <= 0xDEADBEEF) -> all rs_data read 0 immediately; after release, x5 reads 0 and busy_vec = 0.
- x0 protection: write x0 <= 0x12345678 and iss_rd=0 -> rs_addr=0 returns 0, rs_busy=0, busy_vec[0]=0.
- Bypass (BYPASS=1): in the same cycle, wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rs_addr[0]=7 -> rs_data[0]=0xA5A5A5A5 and rs_busy[0]=0. Rerun with BYPASS=0 -> old value, then 0xA5A5A5A5 next cycle.
- Write collision (NUM_WR=2): ports 0 and 1 both write x3 with 0x1 and 0x2 -> x3 reads 0x2 afterwards.
- Scoreboard, issue then writeback: iss x9 -> busy from next cycle; write x9 three cycles later -> busy clears the cycle after. Issue x9 and write x9 in the same cycle -> busy stays 1.
- Flush: set busy on x4, x8, x31, then flush=1 for one cycle -> busy_vec = 0 next cycle, data unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and defaults for the integer register file slice.
package core_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, write ports, issue/scoreboard and flush signals.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rs_addr;
    logic [NUM_RD*XLEN-1:0] rs_data;
    logic [NUM_RD-1:0]      rs_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_valid;
    logic [AW-1:0]          iss_rd;
    logic [NREGS-1:0]       busy_vec;
    logic                   flush;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
        input  rs_data, rs_busy, busy_vec
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
        output rs_data, rs_busy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush > issue set > writeback clear > hold.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_iss_valid,
    input  logic [$clog2(NREGS)-1:0]      i_iss_rd,
    input  logic [NUM_WR-1:0]             i_wr_en,
    input  logic [NUM_WR*$clog2(NREGS)-1:0] i_wr_addr,
    input  logic [NUM_RD*$clog2(NREGS)-1:0] i_rs_addr,
    input  logic [NUM_RD-1:0]             i_fwd_hit,
    output logic [NUM_RD-1:0]             o_rs_busy,
    output logic [NREGS-1:0]              o_busy_vec
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j]) w_busy_nxt[i_wr_addr[j*AW +: AW]] = 1'b0;
            end
            // Applied after the clears so a new producer beats a same-cycle writeback.
            if (i_iss_valid) w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    always_comb begin
        o_rs_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            o_rs_busy[i] = r_busy[i_rs_addr[i*AW +: AW]] & ~i_fwd_hit[i];
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input logic        clk,
    input logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [AW-1:0]     w_rs_addr [NUM_RD];
    logic [AW-1:0]     w_wr_addr [NUM_WR];
    logic [XLEN-1:0]   w_wr_data [NUM_WR];
    logic [XLEN-1:0]   w_rs_data [NUM_RD];
    logic [NUM_RD-1:0] w_fwd_hit;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign w_rs_addr[i] = bus.rs_addr[i*AW +: AW];
        assign bus.rs_data[i*XLEN +: XLEN] = w_rs_data[i];
    end

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign w_wr_addr[j] = bus.wr_addr[j*AW +: AW];
        assign w_wr_data[j] = bus.wr_data[j*XLEN +: XLEN];
    end

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) r_regs[r] <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && (w_wr_addr[j] != AW'(REG_ZERO))) begin
                    r_regs[w_wr_addr[j]] <= w_wr_data[j];
                end
            end
        end
    end

    // Forwarding is suppressed during reset so outputs read zero immediately.
    always_comb begin
        w_fwd_hit = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            w_rs_data[i] = r_regs[w_rs_addr[i]];
            if ((BYPASS != 0) && rst_n && (w_rs_addr[i] != AW'(REG_ZERO))) begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && (w_wr_addr[j] == w_rs_addr[i])) begin
                        w_fwd_hit[i] = 1'b1;
                        w_rs_data[i] = w_wr_data[j];
                    end
                end
            end
            if (w_rs_addr[i] == AW'(REG_ZERO)) w_rs_data[i] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.flush),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .i_wr_en     (bus.wr_en),
        .i_wr_addr   (bus.wr_addr),
        .i_rs_addr   (bus.rs_addr),
        .i_fwd_hit   (w_fwd_hit),
        .o_rs_busy   (bus.rs_busy),
        .o_busy_vec  (bus.busy_vec)
    );

endmodule
